serial_alu_sequencer: RTL and testbench
=======================================

// Module: serial_alu_sequencer
// PURPOSE
//  Multi-cycle driver for a single external one-bit ALU slice. Evaluates a
//  WIDTH-bit AND/OR/ADD/SUB/SLT one bit per clock, LSB first, by feeding the
//  slice operands and carry and collecting its outputs.
//  Sits in the area-reduced datapath option between decode and writeback.
//  Initiator side of the slice interface: a, b, less, cin, aluop in; cout, out back.
// PARAMETERS
//  WIDTH   32   operand/result width; >= 2
// PORTS
//  clk          in   1      single clock, rising edge
//  reset        in   1      synchronous, active-high
//  start        in   1      request; accepted only in IDLE
//  op_a         in   WIDTH  operand A, sampled on accept
//  op_b         in   WIDTH  operand B, sampled on accept
//  aluop        in   3      [2]=invert b & cin=1; [1:0] 00 and,01 or,10 add,11 slt
//  busy         out  1      high in RUN and DONE
//  done         out  1      one-cycle pulse; result/flags valid from this cycle
//  result       out  WIDTH  held until the next accept
//  zero         out  1      result == 0, held with result
//  carry_out    out  1      final slice cout (add/sub only; 0 otherwise)
//  overflow     out  1      see CONFIGURATION
//  slice_a      out  1      op_a[bit]
//  slice_b      out  1      op_b[bit]
//  slice_less   out  1      constant 0
//  slice_cin    out  1      aluop[2] at bit 0, else registered slice_cout
//  slice_aluop  out  3      effective op; [1:0]==11 is driven as 3'b110
//  slice_cout   in   1      slice carry out, combinational in the same cycle
//  slice_out    in   1      slice result bit, combinational in the same cycle
// BEHAVIOUR
//  - Reset values: busy=0, done=0, result=0, zero=1, carry_out=0, overflow=0,
//    slice_* = 0, state=IDLE, bit index=0.
//  - FSM: IDLE -(start)-> RUN; RUN -(bit==WIDTH-1)-> DONE; DONE -> IDLE.
//  - Accept: operands and aluop latched; bit=0; start in RUN/DONE ignored.
//  - RUN: bit i is evaluated in RUN cycle i. slice_out goes to result[i];
//    slice_cout goes to the carry flop. The bit index increments each cycle.
//  - SLT ([1:0]==11): the slice performs a subtraction. At bit WIDTH-1 the sum
//    MSB is captured. In DONE, result={WIDTH-1 zeros, slt_bit}.
//  - aluop 100/101: passed through unchanged. The result is a&~b or a|~b.
//  - Latency: accept at edge N; done is high during cycle N+WIDTH+1.
//    Back-to-back: start may be high in the done cycle but is accepted in
//    the following IDLE cycle. Throughput is 1 op per WIDTH+2 cycles.
//  - zero/carry_out/overflow update in DONE together with result. They are
//    stable in IDLE.
//  - Reset during RUN/DONE: abort, no done pulse, all outputs return to reset
//    values on the next edge.
//  - Carry wrap: the carry out of the MSB is not fed back. The carry flop is
//    reloaded from aluop[2] on every accept.
// CONFIGURATION
//  SERIAL_ALU_OVF_EN defined:
//    - overflow = cin_msb ^ cout_msb for add/sub, 0 otherwise.
//    - SLT uses the signed rule: slt_bit = sum_msb ^ overflow.
//  SERIAL_ALU_OVF_EN undefined:
//    - overflow tied 0.
//    - slt_bit = sum_msb (MIPS slt without overflow correction).
// TESTING (WIDTH=32, bench models the slice behaviourally)
//  1 add 0x7FFFFFFF+1, aluop=010 -> done at cycle 33 after accept.
//    Expect result=0x80000000, carry_out=0; overflow=1 only with _EN.
//  2 sub 5-5, aluop=110 -> result=0, zero=1, carry_out=1.
//  3 slt a=0x80000000, b=1, aluop=111.
//    With _EN: result=1. Without _EN: result=0, since sum MSB=0.
//  4 and 0xF0F0F0F0 & 0xFF00FF00 -> 0xF000F000.
//    or -> 0xFFF0FFF0. Check slice_less=0 throughout.
//  5 start held high continuously -> exactly one accept per 34 cycles.
//    busy is low only in the IDLE cycle.
//  6 reset asserted at RUN bit 10 -> next cycle busy=0, result=0, zero=1, no done.
//    A new start then completes normally.

Source files
------------

// File: rtl/serial_alu_sequencer.sv
// Bit-serial sequencer for an external one-bit ALU slice: AND/OR/ADD/SUB/SLT, LSB first.
// Optional macro SERIAL_ALU_OVF_EN enables the overflow flag and the signed SLT rule.
module serial_alu_sequencer #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [WIDTH-1:0] op_a,
    input  logic [WIDTH-1:0] op_b,
    input  logic [2:0]       aluop,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result,
    output logic             zero,
    output logic             carry_out,
    output logic             overflow,
    output logic             slice_a,
    output logic             slice_b,
    output logic             slice_less,
    output logic             slice_cin,
    output logic [2:0]       slice_aluop,
    input  logic             slice_cout,
    input  logic             slice_out
);

    localparam int BW = (WIDTH > 2) ? $clog2(WIDTH) : 1;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [BW-1:0]    bit_q, bit_d;
    logic [2:0]       aluop_q, aluop_d;
    logic             carry_q, carry_d;
    logic             result_zero_q, result_zero_d;
    logic             cout_q, cout_d;
    logic             ovf_q, ovf_d;
    logic [WIDTH-1:0] result_q, result_d;

    // Data-only registers: no reset, always written before being consumed.
    logic [WIDTH-1:0] op_a_q, op_a_d;
    logic [WIDTH-1:0] op_b_q, op_b_d;
    logic [WIDTH-1:0] acc_q, acc_d;

    logic             in_run;
    logic             last_bit;
    logic             is_add;
    logic             is_slt;
    logic [2:0]       eff_op;
    logic             slt_bit;
    logic             ovf_flag;
    logic [WIDTH-1:0] shifted;
    logic [WIDTH-1:0] res_full;

    assign in_run   = (state_q == S_RUN);
    assign last_bit = (bit_q == BW'(WIDTH - 1));
    assign is_add   = (aluop_q[1:0] == 2'b10);
    assign is_slt   = (aluop_q[1:0] == 2'b11);
    // SLT is carried out as a subtraction on the slice.
    assign eff_op   = is_slt ? 3'b110 : aluop_q;
    assign shifted  = {slice_out, acc_q[WIDTH-1:1]};

`ifdef SERIAL_ALU_OVF_EN
    logic msb_ovf;
    assign msb_ovf  = carry_q ^ slice_cout;
    assign slt_bit  = slice_out ^ msb_ovf;
    assign ovf_flag = is_add & msb_ovf;
`else
    assign slt_bit  = slice_out;
    assign ovf_flag = 1'b0;
`endif

    assign res_full = is_slt ? {{(WIDTH-1){1'b0}}, slt_bit} : shifted;

    always_comb begin
        state_d       = state_q;
        bit_d         = bit_q;
        aluop_d       = aluop_q;
        carry_d       = carry_q;
        result_zero_d = result_zero_q;
        cout_d        = cout_q;
        ovf_d         = ovf_q;
        result_d      = result_q;
        op_a_d        = op_a_q;
        op_b_d        = op_b_q;
        acc_d         = acc_q;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d = S_RUN;
                    bit_d   = '0;
                    op_a_d  = op_a;
                    op_b_d  = op_b;
                    aluop_d = aluop;
                    carry_d = aluop[2] | (aluop[1:0] == 2'b11);
                end
            end
            S_RUN: begin
                acc_d   = shifted;
                carry_d = slice_cout;
                bit_d   = bit_q + BW'(1);
                // Final bit: publish result and flags so they are valid with done.
                if (last_bit) begin
                    state_d       = S_DONE;
                    bit_d         = '0;
                    result_d      = res_full;
                    result_zero_d = (res_full == '0);
                    cout_d        = is_add & slice_cout;
                    ovf_d         = ovf_flag;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= S_IDLE;
            bit_q         <= '0;
            aluop_q       <= 3'b000;
            carry_q       <= 1'b0;
            result_zero_q <= 1'b1;
            cout_q        <= 1'b0;
            ovf_q         <= 1'b0;
            result_q      <= '0;
        end else begin
            state_q       <= state_d;
            bit_q         <= bit_d;
            aluop_q       <= aluop_d;
            carry_q       <= carry_d;
            result_zero_q <= result_zero_d;
            cout_q        <= cout_d;
            ovf_q         <= ovf_d;
            result_q      <= result_d;
        end
    end

    always_ff @(posedge clk) begin
        op_a_q <= op_a_d;
        op_b_q <= op_b_d;
        acc_q  <= acc_d;
    end

    // Slice inputs are driven only while a bit is being evaluated.
    always_comb begin
        slice_a     = 1'b0;
        slice_b     = 1'b0;
        slice_cin   = 1'b0;
        slice_aluop = 3'b000;
        if (in_run) begin
            slice_a     = op_a_q[bit_q];
            slice_b     = op_b_q[bit_q];
            slice_cin   = (bit_q == '0) ? eff_op[2] : carry_q;
            slice_aluop = eff_op;
        end
    end

    assign slice_less = 1'b0;
    assign busy       = (state_q != S_IDLE);
    assign done       = (state_q == S_DONE);
    assign result     = result_q;
    assign zero       = result_zero_q;
    assign carry_out  = cout_q;
    assign overflow   = ovf_q;

endmodule

// File: tb/tb_serial_alu_sequencer.sv
// Randomized self-checking bench for serial_alu_sequencer with a behavioural one-bit slice.
module tb_serial_alu_sequencer;

    localparam int W = 32;

    logic         clk = 1'b0;
    logic         reset;
    logic         start;
    logic [W-1:0] op_a;
    logic [W-1:0] op_b;
    logic [2:0]   aluop;
    logic         busy;
    logic         done;
    logic [W-1:0] result;
    logic         zero;
    logic         carry_out;
    logic         overflow;
    logic         slice_a;
    logic         slice_b;
    logic         slice_less;
    logic         slice_cin;
    logic [2:0]   slice_aluop;
    logic         slice_cout;
    logic         slice_out;

    int vectors    = 0;
    int miscompares = 0;

    serial_alu_sequencer #(.WIDTH(W)) dut (
        .clk         (clk),
        .reset       (reset),
        .start       (start),
        .op_a        (op_a),
        .op_b        (op_b),
        .aluop       (aluop),
        .busy        (busy),
        .done        (done),
        .result      (result),
        .zero        (zero),
        .carry_out   (carry_out),
        .overflow    (overflow),
        .slice_a     (slice_a),
        .slice_b     (slice_b),
        .slice_less  (slice_less),
        .slice_cin   (slice_cin),
        .slice_aluop (slice_aluop),
        .slice_cout  (slice_cout),
        .slice_out   (slice_out)
    );

    always #5 clk = ~clk;

    // Behavioural one-bit ALU slice (MIPS style).
    logic bb_m;
    always_comb begin
        bb_m       = slice_b ^ slice_aluop[2];
        slice_cout = (slice_a & bb_m) | (slice_a & slice_cin) | (bb_m & slice_cin);
        case (slice_aluop[1:0])
            2'b00:   slice_out = slice_a & bb_m;
            2'b01:   slice_out = slice_a | bb_m;
            2'b10:   slice_out = slice_a ^ bb_m ^ slice_cin;
            default: slice_out = slice_less;
        endcase
    end

    // Word-level reference model.
    task automatic model(input logic [W-1:0] a, input logic [W-1:0] b, input logic [2:0] op,
                         output logic [W-1:0] r, output logic z, output logic c, output logic v);
        logic [W-1:0] bb;
        logic [W:0]   s;
        longint       t;
        bb = op[2] ? ~b : b;
        c = 1'b0;
        v = 1'b0;
        r = '0;
        case (op[1:0])
            2'b00: r = a & bb;
            2'b01: r = a | bb;
            2'b10: begin
                s = {1'b0, a} + {1'b0, bb} + {{W{1'b0}}, op[2]};
                r = s[W-1:0];
                c = s[W];
                if (op[2]) t = longint'($signed(a)) - longint'($signed(b));
                else       t = longint'($signed(a)) + longint'($signed(b));
`ifdef SERIAL_ALU_OVF_EN
                v = (t > 64'sd2147483647) || (t < -64'sd2147483648);
`else
                v = 1'b0;
`endif
            end
            default: begin
`ifdef SERIAL_ALU_OVF_EN
                r = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
`else
                s = {1'b0, a} - {1'b0, b};
                r = {31'd0, s[W-1]};
`endif
            end
        endcase
        z = (r == '0);
    endtask

    task automatic run_op(input string name, input logic [W-1:0] a, input logic [W-1:0] b,
                          input logic [2:0] op);
        logic [W-1:0] er;
        logic         ez, ec, ev, slice_ok;
        logic [2:0]   eff;
        int           lat;
        model(a, b, op, er, ez, ec, ev);
        eff = (op[1:0] == 2'b11) ? 3'b110 : op;
        @(negedge clk);
        op_a = a; op_b = b; aluop = op; start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        op_a = $urandom; op_b = $urandom; aluop = 3'($urandom);
        lat = 0;
        slice_ok = 1'b1;
        // Counting the accept (IDLE) cycle as cycle 0, RUN is cycles 1..W and done is cycle W+1.
        for (int k = 1; k <= W + 8; k++) begin
            if (k <= W) begin
                if (slice_a !== a[k-1] || slice_b !== b[k-1] || slice_aluop !== eff ||
                    slice_less !== 1'b0 || busy !== 1'b1 || done !== 1'b0)
                    slice_ok = 1'b0;
            end
            @(posedge clk);
            #1;
            if (done === 1'b1) begin
                lat = k;
                break;
            end
        end
        vectors++;
        if (!slice_ok) begin
            miscompares++;
            $display("FAIL %s slice_drive: a=%h b=%h op=%b got bad slice/busy values, required operand bits, aluop=%b, less=0", name, a, b, op, eff);
        end
        vectors++;
        if (lat != W) begin
            miscompares++;
            $display("FAIL %s latency: got %0d edges after accept, required %0d", name, lat, W);
        end
        vectors++;
        if (result !== er || zero !== ez || carry_out !== ec || overflow !== ev || busy !== 1'b1) begin
            miscompares++;
            $display("FAIL %s result: a=%h b=%h op=%b got r=%h z=%b c=%b v=%b busy=%b required r=%h z=%b c=%b v=%b busy=1",
                     name, a, b, op, result, zero, carry_out, overflow, busy, er, ez, ec, ev);
        end
        @(posedge clk);
        #1;
        vectors++;
        if (done !== 1'b0 || busy !== 1'b0 || result !== er || zero !== ez || slice_aluop !== 3'b000) begin
            miscompares++;
            $display("FAIL %s post_done: got done=%b busy=%b r=%h z=%b slice_aluop=%b required 0 0 %h %b 000",
                     name, done, busy, result, zero, slice_aluop, er, ez);
        end
    endtask

    task automatic test_reset();
        reset = 1'b1; start = 1'b0; op_a = '1; op_b = '1; aluop = 3'b010;
        repeat (3) @(posedge clk);
        #1;
        vectors++;
        if (busy !== 1'b0 || done !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_ctrl: got busy=%b done=%b required 0 0", busy, done);
        end
        vectors++;
        if (result !== '0 || zero !== 1'b1 || carry_out !== 1'b0 || overflow !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_flags: got r=%h z=%b c=%b v=%b required 0 1 0 0", result, zero, carry_out, overflow);
        end
        vectors++;
        if ({slice_a, slice_b, slice_less, slice_cin, slice_aluop} !== 7'd0) begin
            miscompares++;
            $display("FAIL reset_slice: got %b required 0000000", {slice_a, slice_b, slice_less, slice_cin, slice_aluop});
        end
        @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic test_directed();
        run_op("add_ovf", 32'h7FFF_FFFF, 32'h0000_0001, 3'b010);
        run_op("sub_eq",  32'd5, 32'd5, 3'b110);
        run_op("slt_min", 32'h8000_0000, 32'h0000_0001, 3'b111);
        run_op("and",     32'hF0F0_F0F0, 32'hFF00_FF00, 3'b000);
        run_op("or",      32'hF0F0_F0F0, 32'hFF00_FF00, 3'b001);
        run_op("andn",    32'hF0F0_F0F0, 32'hFF00_FF00, 3'b100);
        run_op("orn",     32'hF0F0_F0F0, 32'hFF00_FF00, 3'b101);
        run_op("sub_brw", 32'd3, 32'd9, 3'b110);
    endtask

    task automatic test_random();
        logic [2:0] ops [7] = '{3'b000, 3'b001, 3'b010, 3'b110, 3'b111, 3'b100, 3'b101};
        for (int i = 0; i < 24; i++)
            run_op("rand", $urandom, (i % 4 == 0) ? 32'($urandom_range(0, 3)) : $urandom, ops[$urandom_range(0, 6)]);
    endtask

    task automatic test_back_to_back();
        logic [W-1:0] er;
        logic         ez, ec, ev;
        int           lows, dones, last_done, bad_gap, bad_res;
        model(32'h1234_5678, 32'h0F0F_0F0F, 3'b010, er, ez, ec, ev);
        lows = 0; dones = 0; last_done = -1; bad_gap = 0; bad_res = 0;
        @(negedge clk);
        op_a = 32'h1234_5678; op_b = 32'h0F0F_0F0F; aluop = 3'b010; start = 1'b1;
        for (int k = 1; k <= 3 * (W + 2); k++) begin
            @(posedge clk);
            #1;
            if (busy === 1'b0) lows++;
            if (done === 1'b1) begin
                dones++;
                if (result !== er) bad_res++;
                if (last_done >= 0 && k - last_done != W + 2) bad_gap++;
                last_done = k;
            end
        end
        start = 1'b0;
        vectors++;
        if (dones != 3 || bad_gap != 0) begin
            miscompares++;
            $display("FAIL b2b_accepts: got %0d dones with %0d bad gaps, required 3 dones spaced %0d", dones, bad_gap, W + 2);
        end
        vectors++;
        if (lows != 3) begin
            miscompares++;
            $display("FAIL b2b_idle: got %0d busy-low cycles, required 3", lows);
        end
        vectors++;
        if (bad_res != 0) begin
            miscompares++;
            $display("FAIL b2b_result: got %0d wrong results, required 0", bad_res);
        end
        repeat (2) @(posedge clk);
    endtask

    task automatic test_abort();
        int seen_done;
        run_op("pre_abort", 32'h0000_00FF, 32'h0, 3'b001);
        @(negedge clk);
        op_a = 32'hDEAD_BEEF; op_b = 32'h0000_1111; aluop = 3'b010; start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (10) @(posedge clk);
        #1;
        reset = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
        vectors++;
        if (busy !== 1'b0 || done !== 1'b0 || result !== '0 || zero !== 1'b1 || carry_out !== 1'b0 || overflow !== 1'b0) begin
            miscompares++;
            $display("FAIL abort_state: got busy=%b done=%b r=%h z=%b c=%b v=%b required 0 0 0 1 0 0",
                     busy, done, result, zero, carry_out, overflow);
        end
        seen_done = 0;
        for (int k = 0; k < W + 8; k++) begin
            @(posedge clk);
            #1;
            if (done === 1'b1 || busy === 1'b1) seen_done++;
        end
        vectors++;
        if (seen_done != 0) begin
            miscompares++;
            $display("FAIL abort_quiet: got %0d busy/done cycles after abort, required 0", seen_done);
        end
        run_op("post_abort", 32'hDEAD_BEEF, 32'h0000_1111, 3'b010);
    endtask

    initial begin
        test_reset();
        test_directed();
        test_random();
        test_back_to_back();
        test_abort();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
